// File: rtl/norz_xpt_pkg.sv
// Shared types and constants for the prefix/T-state sequencer.
// Optional feature macro used by the sequencer: XPT_WAIT_EN.
package norz_xpt_pkg;

  localparam int XPT_W = 5;
  localparam logic [XPT_W-1:0] XPT_MAX = 5'd31;

  localparam logic [7:0] OP_PREFIX_DD = 8'hDD;
  localparam logic [7:0] OP_PREFIX_FD = 8'hFD;

  typedef enum logic {
    M1_FETCH = 1'b0,
    EXEC     = 1'b1
  } seq_state_t;

  // True for either index-register prefix byte.
  function automatic logic is_index_prefix(input logic [7:0] op);
    return (op == OP_PREFIX_DD) || (op == OP_PREFIX_FD);
  endfunction

endpackage

// File: rtl/xpt_counter.sv
// T-state step counter: load-zero, increment, saturate at XPT_MAX with a
// sticky overflow flag that only reset clears.
module xpt_counter
  import norz_xpt_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_zero,
  input  logic             inc,
  output logic [XPT_W-1:0] count,
  output logic             overflow
);

  // Load-zero beats increment; an increment at the ceiling holds and flags overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (load_zero) begin
      count <= '0;
    end else if (inc) begin
      if (count == XPT_MAX) begin
        overflow <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/xpt_prefix_sequencer.sv
// Opcode-fetch / execute sequencer with DD/FD index-prefix latching.
// Optional macro XPT_WAIT_EN: when defined, wait_req freezes all state
// changes; when undefined, wait_req is accepted but has no effect.
module xpt_prefix_sequencer
  import norz_xpt_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             opcode_valid,
  input  logic [7:0]       opcode,
  input  logic             PR_Reset_XPT,
  input  logic             P2_Set_CM1,
  input  logic             P2_Reset_XIX,
  input  logic             P2_Reset_XIY,
  input  logic             wait_req,
  output logic [XPT_W-1:0] XPT,
  output logic [XPT_W-1:0] notXPT,
  output logic             CM1,
  output logic             is_Y,
  output logic             xix_active,
  output logic             enable_XIX,
  output logic             int_block,
  output logic             xpt_overflow
);

  seq_state_t state, state_next;
  logic       xix_flag, xix_next;
  logic       xiy_flag, xiy_next;
  logic       advance;
  logic       cnt_load_zero;
  logic       cnt_inc;
  logic       set_xix;
  logic       set_xiy;
  logic       start_exec;

`ifdef XPT_WAIT_EN
  assign advance = step & ~wait_req;
`else
  logic unused_wait_req;
  assign unused_wait_req = wait_req;
  assign advance         = step;
`endif

  // Next-state, flag updates and counter controls for one advancing step.
  always_comb begin
    state_next    = state;
    xix_next      = xix_flag;
    xiy_next      = xiy_flag;
    cnt_load_zero = 1'b0;
    cnt_inc       = 1'b0;
    set_xix       = 1'b0;
    set_xiy       = 1'b0;
    start_exec    = 1'b0;

    if (advance) begin
      if (state == M1_FETCH) begin
        if (opcode_valid) begin
          set_xix    = (opcode == OP_PREFIX_DD);
          set_xiy    = (opcode == OP_PREFIX_FD);
          start_exec = !is_index_prefix(opcode);
        end
        if (start_exec) begin
          state_next = EXEC;
          cnt_inc    = 1'b1;
        end else if (set_xix || set_xiy) begin
          cnt_load_zero = 1'b1;
        end
      end else begin
        cnt_inc = 1'b1;
      end

      if (PR_Reset_XPT || P2_Set_CM1) begin
        cnt_load_zero = 1'b1;
        cnt_inc       = 1'b0;
      end
      if (P2_Set_CM1) begin
        state_next = M1_FETCH;
      end

      if (P2_Reset_XIX) begin
        xix_next = 1'b0;
      end
      if (P2_Reset_XIY) begin
        xiy_next = 1'b0;
      end
      if (set_xix) begin
        xix_next = 1'b1;
        xiy_next = 1'b0;
      end
      if (set_xiy) begin
        xiy_next = 1'b1;
        xix_next = 1'b0;
      end
    end
  end

  // State and prefix flags; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= M1_FETCH;
      xix_flag <= 1'b0;
      xiy_flag <= 1'b0;
    end else begin
      state    <= state_next;
      xix_flag <= xix_next;
      xiy_flag <= xiy_next;
    end
  end

  xpt_counter u_xpt_counter (
    .clk       (clk),
    .reset     (reset),
    .load_zero (cnt_load_zero),
    .inc       (cnt_inc),
    .count     (XPT),
    .overflow  (xpt_overflow)
  );

  assign notXPT     = ~XPT;
  assign CM1        = (state == M1_FETCH);
  assign is_Y       = xiy_flag;
  assign xix_active = xix_flag | xiy_flag;
  assign enable_XIX = xix_active & (state == EXEC);
  assign int_block  = xix_active & (state == M1_FETCH);

endmodule

// File: doc/xpt_prefix_sequencer.md
XPT_PREFIX_SEQUENCER -- requirements
Module: xpt_prefix_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset; sampled on rising clk.
REQ-003 SHALL have ports: step  in  1  T-state advance strobe; state changes only when step=1.
REQ-004 SHALL have ports: opcode_valid  in  1  opcode byte present on opcode this step (M1 only).
REQ-005 SHALL have ports: opcode  in  8  fetched opcode byte.
REQ-006 SHALL have ports: PR_Reset_XPT, P2_Set_CM1, P2_Reset_XIX, P2_Reset_XIY  in  1 each  decoder step-end commands.
REQ-007 SHALL have ports: wait_req  in  1  bus wait-state request.
REQ-008 SHALL have ports: XPT / notXPT  out  5 / 5  step counter and its bitwise complement.
REQ-009 SHALL have ports: CM1  out  1  M1 (opcode fetch) phase active.
REQ-010 SHALL have ports: is_Y, xix_active  out  1 each  IY prefix latched; any index prefix latched.
REQ-011 SHALL have ports: enable_XIX  out  1  enable for the DD/FD-prefixed decoder bank.
REQ-012 SHALL have ports: int_block, xpt_overflow  out  1 each  interrupt inhibit; sticky overflow error.

Function
REQ-013 SHALL implement states M1_FETCH, EXEC; CM1=1 exactly in M1_FETCH.
REQ-014 In M1_FETCH with step & opcode_valid: opcode 8'hDD SHALL set XIX flag, clear XIY flag, remain M1_FETCH, hold XPT=0.
REQ-015 Opcode 8'hFD SHALL set XIY flag, clear XIX flag, remain M1_FETCH; last prefix of a DD/FD chain wins.
REQ-016 Any other opcode SHALL move to EXEC on the same step with XPT=1 next cycle.
REQ-017 In EXEC, each step SHALL increment XPT by 1; opcode_valid ignored.
REQ-018 XPT at 31 with step SHALL hold 31 and set xpt_overflow (sticky until reset).
REQ-019 PR_Reset_XPT with step SHALL load XPT=0, overriding increment.
REQ-020 P2_Set_CM1 with step SHALL move to M1_FETCH; with PR_Reset_XPT absent, XPT still loads 0.
REQ-021 P2_Reset_XIX / P2_Reset_XIY with step SHALL clear the respective flag; in the same step as a prefix set, the set wins.
REQ-022 notXPT SHALL equal ~XPT every cycle (combinational).
REQ-023 is_Y = XIY flag; xix_active = XIX|XIY; enable_XIX = xix_active & (state==EXEC).
REQ-024 int_block SHALL be 1 whenever xix_active=1 and state==M1_FETCH (no interrupt between prefix and opcode).
REQ-025 All inputs SHALL be ignored when step=0; outputs hold.

Reset
REQ-026 reset SHALL force M1_FETCH, XPT=0, notXPT=5'h1F, CM1=1, flags 0, is_Y=0, enable_XIX=0, int_block=0, xpt_overflow=0, next cycle, overriding step and all commands.
REQ-027 Reset mid-EXEC SHALL abandon the instruction; no command effect in that cycle.

Configuration
REQ-028 Macro XPT_WAIT_EN defined: wait_req=1 SHALL suppress the effect of step (full freeze of state, XPT, flags).
REQ-029 XPT_WAIT_EN undefined: wait_req port SHALL remain but be ignored.

Structure
REQ-030 Package norz_xpt_pkg SHALL hold the state enum, XPT_W=5, XPT_MAX=31, OP_PREFIX_DD=8'hDD, OP_PREFIX_FD=8'hFD.
REQ-031 XPT counter (load-zero, increment, saturate, overflow flag) SHALL be sub-module xpt_counter.

Verification
REQ-032 Reset, then step with opcode 8'hDD, then 8'hF9 -> XIX=1, CM1=1, int_block=1, then EXEC, XPT=1, enable_XIX=1, is_Y=0.
REQ-033 Opcodes DD,FD,F9 -> is_Y=1, xix_active=1; at XPT=3 assert PR_Reset_XPT+P2_Set_CM1+P2_Reset_XIY -> XPT=0, CM1=1, xix_active=0.
REQ-034 EXEC, 40 steps with no commands -> XPT stops at 31, xpt_overflow=1 until reset.
REQ-035 reset asserted at XPT=5 with P2_Set_CM1 -> next cycle all REQ-026 values; step=0 cycles -> no change.
REQ-036 XPT_WAIT_EN defined, wait_req=1 for 3 steps at XPT=2 -> XPT stays 2; undefined -> XPT reaches 5.
